ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shares the single external SRAM among three requesters: the 6502 CPU, video fetch, and the Wishbone/SPI bridge from the MCU. The block grants one non-preemptive transaction at a time and drives the SRAM control strobes for a fixed access window sized from the SRAM access time. It sits between the bus-decode/requester logic and the SRAM pins at top level.

## Interface
- `ACCESS_CYCLES`, default `common_pkg::ns_to_cycles(common_pkg::RAM_ACCESS_NS)` = 4 at 64 MHz/55 ns. Number of cycles CE and OE/WE stay asserted. Must be ≥ 1.
- `clock_i`  in  1  system clock, `SYS_CLOCK_MHZ`.
- `reset_n_i`  in  1  reset: one clock, synchronous, active-low.
- For each requester `X` ∈ {`cpu`, `video`, `wb`}, the following five ports:
  - `X_req_i`  in  1  request. Level; held until ack.
  - `X_we_i`  in  1  1 = write, 0 = read.
  - `X_addr_i`  in  `RAM_ADDR_WIDTH` (17)  SRAM word address.
  - `X_wr_data_i`  in  `DATA_WIDTH` (8)  write data.
  - `X_ack_o`  out  1  one-cycle completion pulse.
- `rd_data_o`  out  8  registered read data, shared by all requesters. Valid in any ack cycle of a read.
- `grant_o`  out  2  current owner (`ram_owner_t`). `OWNER_NONE` when idle.
- `ram_addr_o`  out  17  SRAM address.
- `ram_data_o`  out  8  SRAM write data.
- `ram_data_oe_o`  out  1  FPGA drives the SRAM data bus.
- `ram_data_i`  in  8  SRAM read data.
- `ram_ce_n_o`, `ram_oe_n_o`, `ram_we_n_o`  out  1 each  SRAM strobes, active-low.

## Operation
- FSM has three states: IDLE → ACCESS → RECOVER → IDLE.
- **IDLE**
  - Samples all `*_req_i` every cycle.
  - If any is high, it latches the winner's addr, we and wr_data into registers.
  - Sets `grant_o` and loads `count = ACCESS_CYCLES-1`.
  - Next state is ACCESS.
  - Requests are never pre-registered; the choice is made on the IDLE cycle's inputs.
- **Arbitration**
  - CPU has fixed top priority.
  - Video and wb share a round-robin pointer. The pointer flips to the other requester after each video or wb grant and is unchanged by CPU grants.
  - The pointer resets to favour video.
- **ACCESS**
  - `ram_ce_n_o` = 0 and `ram_addr_o` = latched addr.
  - Read: `ram_oe_n_o` = 0 and `ram_data_oe_o` = 0.
  - Write: `ram_we_n_o` = 0, `ram_data_oe_o` = 1, `ram_data_o` = latched data.
  - `count` decrements each cycle. At `count == 0`, the next state is RECOVER and, for reads, `ram_data_i` is captured into `rd_data_o`.
- **RECOVER**
  - All strobes are deasserted (CE, OE and WE = 1).
  - Address and write data stay driven, giving hold time after the WE rising edge.
  - `X_ack_o` = 1 for the owner only.
  - Next state is IDLE and `grant_o` returns to `OWNER_NONE`.
- **Handshake**
  - A requester drops req on the edge at which it samples ack high. Otherwise IDLE starts a new transaction.
  - Dropping req mid-transaction does not abort it. The access still completes and ack still pulses.
  - Changing addr, we or wr_data after the IDLE cycle has no effect, because they are latched.
- **Reset**
  - On the first edge with `reset_n_i` = 0, the state goes to IDLE, even mid-ACCESS.
  - No ack is issued for the aborted transaction.
  - CE, OE and WE go to 1, `ram_data_oe_o` to 0, `rd_data_o` to 0, `ram_addr_o` to 0, `ram_data_o` to 0, `grant_o` to `OWNER_NONE`, and the pointer to video.

## Timing
- Request visible in IDLE cycle n: ACCESS spans cycles n+1 … n+ACCESS_CYCLES, and ack is high in cycle n+ACCESS_CYCLES+1.
- Minimum period per transaction is ACCESS_CYCLES+2 cycles: 6 cycles = 93.75 ns at the defaults.
- A CPU request waits at most one in-flight transaction: ≤ 2·(ACCESS_CYCLES+2) cycles from assertion to ack.
- All outputs are registered. There is no combinational path from `*_req_i` to any output.
- `ram_data_oe_o` and `ram_we_n_o` switch on the same edge. Because data stays driven through RECOVER, the bus is never undriven while WE is low.

## Structure
- Add to `common_pkg`:
  - `localparam int unsigned RAM_ACCESS_NS = 55;`
  - `typedef enum logic [1:0] { OWNER_NONE, OWNER_CPU, OWNER_VIDEO, OWNER_WB } ram_owner_t;`
- Keep the FSM state enum local to the module.
- One sub-module, `ram_arbiter_pick`: purely combinational. Takes the req vector and rr pointer and returns a `ram_owner_t`. It is unit-testable in isolation.
- The counter width is `$clog2(ACCESS_CYCLES)`, minimum 1 bit.

## Test plan
- **Single CPU read:** preload SRAM model addr 0x1_2345 = 0xA5, `cpu_req` with we=0.
  - Ack arrives exactly 5 cycles after the IDLE sample.
  - `rd_data_o` = 0xA5.
  - `ram_oe_n_o` is low for exactly 4 cycles.
- **wb write:** addr 0x0_8000, data 0x3C.
  - `ram_we_n_o` is low for 4 cycles with `ram_data_oe_o` = 1.
  - Addr and data stay stable through RECOVER.
  - A model readback gives 0x3C.
- **Simultaneous requests:** video and wb hold req continuously, and CPU pulses req during the 2nd transaction.
  - Grant order is video, wb, CPU, then video, wb …; the CPU is served next after the in-flight access.
- **Reset mid-ACCESS:** hold `reset_n_i` = 0 for 1 cycle during the 2nd ACCESS cycle of a write.
  - Next cycle: WE and CE = 1, `ram_data_oe_o` = 0, `grant_o` = `OWNER_NONE`, no ack.
  - After release, the pointer favours video.
- **Requester drops req in ACCESS:** the transaction completes, ack pulses once, and no second transaction is started.
- **Back-to-back:** CPU holds req across two acks.
  - Two accesses occur with exactly one IDLE cycle between RECOVER and the next ACCESS.

Source files
------------

// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_pkg
// Description : System-wide constants, SRAM owner encoding and the
//               nanosecond-to-clock-cycle helper shared across the design.
// Revision    : 1.0 - initial release
// ============================================================================
package common_pkg;

    localparam int unsigned SYS_CLOCK_MHZ  = 64;
    localparam int unsigned RAM_ACCESS_NS  = 55;
    localparam int unsigned RAM_ADDR_WIDTH = 17;
    localparam int unsigned DATA_WIDTH     = 8;

    // Bit positions of each requester inside a packed request vector
    localparam int unsigned REQ_CPU   = 0;
    localparam int unsigned REQ_VIDEO = 1;
    localparam int unsigned REQ_WB    = 2;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_CPU   = 2'd1,
        OWNER_VIDEO = 2'd2,
        OWNER_WB    = 2'd3
    } ram_owner_t;

    // Rounds up so the strobe window is never shorter than the device needs
    function automatic int unsigned ns_to_cycles(input int unsigned ns);
        return (ns * SYS_CLOCK_MHZ + 999) / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_pick
// Description : Combinational winner selection for the SRAM arbiter.
//               CPU has fixed priority; video and wb are resolved by a
//               single round-robin pointer when both are requesting.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_pick
    import common_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_rr_favour_wb,
    output ram_owner_t o_owner
);

    // Priority decode: CPU first, then video/wb tie broken by the pointer
    always_comb begin
        o_owner = OWNER_NONE;
        if (i_req[REQ_CPU]) begin
            o_owner = OWNER_CPU;
        end else if (i_req[REQ_VIDEO] && i_req[REQ_WB]) begin
            o_owner = i_rr_favour_wb ? OWNER_WB : OWNER_VIDEO;
        end else if (i_req[REQ_VIDEO]) begin
            o_owner = OWNER_VIDEO;
        end else if (i_req[REQ_WB]) begin
            o_owner = OWNER_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one asynchronous SRAM between CPU, video fetch and the
//               Wishbone bridge. One non-preemptive transaction at a time:
//               IDLE (pick + latch) -> ACCESS (strobes for ACCESS_CYCLES)
//               -> RECOVER (strobes off, ack) -> IDLE. All outputs are
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import common_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = ns_to_cycles(RAM_ACCESS_NS)
) (
    input  logic                      clock_i,
    input  logic                      reset_n_i,

    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]     cpu_wr_data_i,
    output logic                      cpu_ack_o,

    input  logic                      video_req_i,
    input  logic                      video_we_i,
    input  logic [RAM_ADDR_WIDTH-1:0] video_addr_i,
    input  logic [DATA_WIDTH-1:0]     video_wr_data_i,
    output logic                      video_ack_o,

    input  logic                      wb_req_i,
    input  logic                      wb_we_i,
    input  logic [RAM_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_wr_data_i,
    output logic                      wb_ack_o,

    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output ram_owner_t                grant_o,

    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_data_o,
    output logic                      ram_data_oe_o,
    input  logic [DATA_WIDTH-1:0]     ram_data_i,
    output logic                      ram_ce_n_o,
    output logic                      ram_oe_n_o,
    output logic                      ram_we_n_o
);

    localparam int unsigned        c_CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic                      w_start;
    logic                      w_capture;

    ram_owner_t                r_owner;
    logic                      r_we;
    logic                      r_rr_favour_wb;

    ram_owner_t                w_pick;
    logic                      w_win_we;
    logic [RAM_ADDR_WIDTH-1:0] w_win_addr;
    logic [DATA_WIDTH-1:0]     w_win_data;
    logic                      w_we_nxt;

    ram_arbiter_pick u_pick (
        .i_req          ({wb_req_i, video_req_i, cpu_req_i}),
        .i_rr_favour_wb (r_rr_favour_wb),
        .o_owner        (w_pick)
    );

    // Route the winning requester's transaction fields to the latch inputs
    always_comb begin
        w_win_we   = cpu_we_i;
        w_win_addr = cpu_addr_i;
        w_win_data = cpu_wr_data_i;
        case (w_pick)
            OWNER_VIDEO: begin
                w_win_we   = video_we_i;
                w_win_addr = video_addr_i;
                w_win_data = video_wr_data_i;
            end
            OWNER_WB: begin
                w_win_we   = wb_we_i;
                w_win_addr = wb_addr_i;
                w_win_data = wb_wr_data_i;
            end
            default: ;
        endcase
    end

    // FSM state and access-window counter
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and start/capture strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick != OWNER_NONE) begin
                    w_start     = 1'b1;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RECOVER;
                    w_capture   = !r_we;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            ST_RECOVER: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Direction of the transaction that the next state will be serving
    assign w_we_nxt = w_start ? w_win_we : r_we;

    // Latched transaction, round-robin pointer and registered SRAM/ack outputs
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_owner        <= OWNER_NONE;
            r_we           <= 1'b0;
            r_rr_favour_wb <= 1'b0;
            ram_addr_o     <= '0;
            ram_data_o     <= '0;
            rd_data_o      <= '0;
            grant_o        <= OWNER_NONE;
            ram_ce_n_o     <= 1'b1;
            ram_oe_n_o     <= 1'b1;
            ram_we_n_o     <= 1'b1;
            ram_data_oe_o  <= 1'b0;
            cpu_ack_o      <= 1'b0;
            video_ack_o    <= 1'b0;
            wb_ack_o       <= 1'b0;
        end else begin
            if (w_start) begin
                r_owner    <= w_pick;
                r_we       <= w_win_we;
                ram_addr_o <= w_win_addr;
                ram_data_o <= w_win_data;
                // CPU grants leave the video/wb fairness pointer alone
                if (w_pick == OWNER_VIDEO) begin
                    r_rr_favour_wb <= 1'b1;
                end else if (w_pick == OWNER_WB) begin
                    r_rr_favour_wb <= 1'b0;
                end
            end
            if (w_capture) begin
                rd_data_o <= ram_data_i;
            end
            grant_o       <= (w_state_nxt == ST_IDLE) ? OWNER_NONE
                           : (w_start ? w_pick : r_owner);
            ram_ce_n_o    <= !(w_state_nxt == ST_ACCESS);
            ram_oe_n_o    <= !((w_state_nxt == ST_ACCESS) && !w_we_nxt);
            ram_we_n_o    <= !((w_state_nxt == ST_ACCESS) && w_we_nxt);
            // Write data stays on the bus through RECOVER for hold time
            ram_data_oe_o <= (w_state_nxt != ST_IDLE) && w_we_nxt;
            cpu_ack_o     <= (w_state_nxt == ST_RECOVER) && (r_owner == OWNER_CPU);
            video_ack_o   <= (w_state_nxt == ST_RECOVER) && (r_owner == OWNER_VIDEO);
            wb_ack_o      <= (w_state_nxt == ST_RECOVER) && (r_owner == OWNER_WB);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter: table of single
//               transactions, hand-written multi-cycle sequences and a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int          ACC   = 4;
    localparam logic [16:0] RBASE = 17'h00500;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  ack;
    logic [16:0] addr  [3];
    logic [7:0]  wdata [3];
    logic [7:0]  rd_data;
    logic [1:0]  grant;
    logic [16:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        data_oe;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clock_i         (clk),
        .reset_n_i       (reset_n),
        .cpu_req_i       (req[0]),
        .cpu_we_i        (we[0]),
        .cpu_addr_i      (addr[0]),
        .cpu_wr_data_i   (wdata[0]),
        .cpu_ack_o       (ack[0]),
        .video_req_i     (req[1]),
        .video_we_i      (we[1]),
        .video_addr_i    (addr[1]),
        .video_wr_data_i (wdata[1]),
        .video_ack_o     (ack[1]),
        .wb_req_i        (req[2]),
        .wb_we_i         (we[2]),
        .wb_addr_i       (addr[2]),
        .wb_wr_data_i    (wdata[2]),
        .wb_ack_o        (ack[2]),
        .rd_data_o       (rd_data),
        .grant_o         (grant),
        .ram_addr_o      (ram_addr),
        .ram_data_o      (ram_dout),
        .ram_data_oe_o   (data_oe),
        .ram_data_i      (ram_din),
        .ram_ce_n_o      (ce_n),
        .ram_oe_n_o      (oe_n),
        .ram_we_n_o      (we_n)
    );

    // SRAM behavioural model with a bench-side preload port
    logic [7:0]  mem [0:131071];
    logic        pl_en = 1'b0;
    logic [16:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!ce_n && !we_n) mem[ram_addr] <= ram_dout;
    end
    assign ram_din = mem[ram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        req     = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        step();
        pl_en   = 1'b0;
    endtask

    // One isolated transaction; returns observed latency and strobe statistics
    task automatic do_txn(input int who, input bit w, input logic [16:0] a, input logic [7:0] d,
                          output int lat, output int ce_lo, output int oe_lo, output int we_lo,
                          output int strobe_bad, output int hold_bad,
                          output logic [7:0] rd, output logic [1:0] gr);
        lat = -1; ce_lo = 0; oe_lo = 0; we_lo = 0; strobe_bad = 0; hold_bad = 0;
        rd = '0; gr = '0;
        req[who] = 1'b1; we[who] = w; addr[who] = a; wdata[who] = d;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 2) begin
                addr[who]  = ~a;
                wdata[who] = ~d;
                we[who]    = ~w;
            end
            if (!ce_n) ce_lo++;
            if (!oe_n) oe_lo++;
            if (!we_n) begin
                we_lo++;
                if (!data_oe || ram_addr != a || ram_dout != d) strobe_bad++;
            end
            if (ack[who]) begin
                lat = c;
                rd  = rd_data;
                gr  = grant;
                if (ram_addr != a || (w && (ram_dout != d || !data_oe))) hold_bad++;
                req[who] = 1'b0;
                break;
            end
        end
        step();
    endtask

    typedef struct {
        int          who;
        bit          w;
        logic [16:0] a;
        logic [7:0]  d;
        bit          pre;
        logic [7:0]  pre_val;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [8];

    // Random-phase reference model state
    bit          pend [3];
    bit          rr_wb;
    int          next_dec, exp_ack, exp_who, dec_cyc, just_acked;
    bit          exp_w;
    logic [3:0]  exp_off;
    logic [7:0]  exp_d;
    logic [7:0]  ref_mem [16];

    initial begin
        int          lat, ce_lo, oe_lo, we_lo, sbad, hbad;
        logic [7:0]  rd;
        logic [1:0]  gr;
        int          order [$];
        int          exp_ord [5];
        bit          cpu_up, cpu_done;
        int          cpu_t0, cpu_lat, nack, celo, t1, t2, tce, win, anyack, firstack;

        vecs[0] = '{0, 1'b0, 17'h12345, 8'h00, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{2, 1'b1, 17'h08000, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{1, 1'b0, 17'h00000, 8'h00, 1'b1, 8'h5A, 8'h5A};
        vecs[3] = '{2, 1'b0, 17'h08000, 8'h00, 1'b0, 8'h00, 8'h3C};
        vecs[4] = '{0, 1'b1, 17'h1FFFF, 8'hFF, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{1, 1'b0, 17'h1FFFF, 8'h00, 1'b0, 8'h00, 8'hFF};
        vecs[6] = '{1, 1'b1, 17'h00001, 8'h81, 1'b0, 8'h00, 8'h00};
        vecs[7] = '{0, 1'b0, 17'h00001, 8'h00, 1'b0, 8'h00, 8'h81};
        exp_ord = '{2, 3, 1, 2, 3};

        req = '0; we = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end

        // ---- reset state ----
        reset_n = 1'b0;
        step();
        step();
        check("reset_ce_n", ce_n, 1);
        check("reset_oe_n", oe_n, 1);
        check("reset_we_n", we_n, 1);
        check("reset_data_oe", data_oe, 0);
        check("reset_grant", grant, 0);
        check("reset_ack", ack, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_ram_data", ram_dout, 0);
        reset_n = 1'b1;
        step();

        // ---- table of isolated transactions ----
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].pre) preload(vecs[v].a, vecs[v].pre_val);
            do_txn(vecs[v].who, vecs[v].w, vecs[v].a, vecs[v].d,
                   lat, ce_lo, oe_lo, we_lo, sbad, hbad, rd, gr);
            check($sformatf("tbl%0d_latency", v), lat, ACC + 1);
            check($sformatf("tbl%0d_grant", v), gr, vecs[v].who + 1);
            check($sformatf("tbl%0d_ce_low", v), ce_lo, ACC);
            check($sformatf("tbl%0d_oe_low", v), oe_lo, vecs[v].w ? 0 : ACC);
            check($sformatf("tbl%0d_we_low", v), we_lo, vecs[v].w ? ACC : 0);
            check($sformatf("tbl%0d_we_window", v), sbad, 0);
            check($sformatf("tbl%0d_recover_hold", v), hbad, 0);
            if (vecs[v].w) check($sformatf("tbl%0d_mem", v), mem[vecs[v].a], vecs[v].d);
            else           check($sformatf("tbl%0d_rd_data", v), rd, vecs[v].exp_rd);
        end

        // ---- simultaneous video+wb, CPU pulse during 2nd transaction ----
        reset_dut();
        we[1] = 1'b0; addr[1] = 17'h00100;
        we[2] = 1'b0; addr[2] = 17'h00200;
        req[1] = 1'b1; req[2] = 1'b1;
        cpu_up = 1'b0; cpu_done = 1'b0; cpu_t0 = 0; cpu_lat = 999;
        for (int c = 0; c < 150 && order.size() < 5; c++) begin
            step();
            if (!cpu_up && !cpu_done && grant == 2'd3) begin
                cpu_up = 1'b1; we[0] = 1'b0; addr[0] = 17'h00300; req[0] = 1'b1; cpu_t0 = c;
            end
            if (ack != 3'b000) begin
                case (ack)
                    3'b001:  order.push_back(1);
                    3'b010:  order.push_back(2);
                    3'b100:  order.push_back(3);
                    default: order.push_back(0);
                endcase
                if (ack[0]) begin
                    req[0] = 1'b0; cpu_up = 1'b0; cpu_done = 1'b1; cpu_lat = c - cpu_t0;
                end
            end
        end
        req[1] = 1'b0; req[2] = 1'b0;
        step();
        for (int i = 0; i < 5; i++)
            check($sformatf("order_%0d", i), (i < order.size()) ? order[i] : -1, exp_ord[i]);
        check("cpu_wait_bound", (cpu_done && cpu_lat <= 2 * (ACC + 2)) ? 1 : 0, 1);

        // ---- reset during 2nd ACCESS cycle of a write ----
        reset_dut();
        do_txn(1, 1'b0, 17'h00010, 8'h00, lat, ce_lo, oe_lo, we_lo, sbad, hbad, rd, gr);
        we[0] = 1'b1; addr[0] = 17'h00400; wdata[0] = 8'h77; req[0] = 1'b1;
        step();
        step();
        check("rst_pre_we_n", we_n, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        req[0]  = 1'b0;
        check("rst_we_n", we_n, 1);
        check("rst_ce_n", ce_n, 1);
        check("rst_data_oe", data_oe, 0);
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        anyack = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ack != 3'b000) anyack++;
        end
        check("rst_no_late_ack", anyack, 0);
        we[1] = 1'b0; we[2] = 1'b0; req[1] = 1'b1; req[2] = 1'b1;
        firstack = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ack != 3'b000) begin firstack = ack; break; end
        end
        req[1] = 1'b0; req[2] = 1'b0;
        step();
        check("rst_pointer_video", firstack, 3'b010);

        // ---- requester drops req during ACCESS ----
        we[0] = 1'b0; addr[0] = 17'h00020; req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        nack = 0; celo = 0;
        for (int c = 0; c < 14; c++) begin
            if (!ce_n) celo++;
            if (ack[0]) nack++;
            step();
        end
        check("drop_ack_count", nack, 1);
        check("drop_ce_low", celo, ACC);
        check("drop_grant_idle", grant, 0);

        // ---- back-to-back CPU requests ----
        we[0] = 1'b0; addr[0] = 17'h00030; req[0] = 1'b1;
        nack = 0; t1 = -100; t2 = -100; tce = -100;
        for (int c = 0; c < 40; c++) begin
            step();
            if (nack == 1 && !ce_n && tce < 0) tce = c;
            if (ack[0]) begin
                nack++;
                if (nack == 1) t1 = c;
                else begin t2 = c; req[0] = 1'b0; break; end
            end
        end
        step();
        check("b2b_ack_count", nack, 2);
        check("b2b_gap", tce - t1, 2);
        check("b2b_period", t2 - t1, ACC + 2);

        // ---- randomized traffic against the transaction-level model ----
        reset_dut();
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[RBASE + 17'(i)];
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        rr_wb = 1'b0; next_dec = 0; exp_ack = -1; exp_who = 0; dec_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            just_acked = -1;
            if (c == exp_ack) begin
                check("rnd_ack", ack, 3'b001 << exp_who);
                check("rnd_grant", grant, exp_who + 1);
                if (!exp_w) check("rnd_rd_data", rd_data, ref_mem[exp_off]);
                else        ref_mem[exp_off] = exp_d;
                req[exp_who]  = 1'b0;
                pend[exp_who] = 1'b0;
                just_acked    = exp_who;
                next_dec      = c + 1;
                exp_ack       = -1;
            end else if (ack != 3'b000) begin
                check("rnd_spurious_ack", ack, 0);
            end
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && i != just_acked && c < 2800 && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    req[i]   = 1'b1;
                    we[i]    = 1'($urandom_range(0, 1));
                    addr[i]  = RBASE + 17'($urandom_range(0, 15));
                    wdata[i] = 8'($urandom);
                end else if (pend[i] && exp_ack >= 0 && i == exp_who && c > dec_cyc) begin
                    addr[i]  = RBASE + 17'($urandom_range(0, 15));
                    wdata[i] = 8'($urandom);
                    we[i]    = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
                end
            end
            if (c == next_dec) begin
                win = -1;
                if (pend[0]) win = 0;
                else if (pend[1] && pend[2]) win = rr_wb ? 2 : 1;
                else if (pend[1]) win = 1;
                else if (pend[2]) win = 2;
                if (win >= 0) begin
                    exp_who = win;
                    exp_w   = we[win];
                    exp_off = 4'(addr[win] - RBASE);
                    exp_d   = wdata[win];
                    exp_ack = c + ACC + 1;
                    dec_cyc = c;
                    if (win == 1) rr_wb = 1'b1;
                    if (win == 2) rr_wb = 1'b0;
                end else begin
                    next_dec = c + 1;
                end
            end
            step();
        end
        check("rnd_drained", exp_ack, -1);
        for (int i = 0; i < 16; i++)
            check($sformatf("rnd_mem_%0d", i), mem[RBASE + 17'(i)], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
